// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader uses the master modport; the host link / memory side uses slave.
interface imem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: parses LEN_HI/LEN_LO/payload/CHK byte frames, writes
// big-endian words to instruction memory and holds the CPU until a good load.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          error,
  output logic [15:0]   words_loaded
);
  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERR} state_t;
  state_t state, state_nx;

  logic [7:0]  len_hi;
  logic [15:0] n_words;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_word;
  logic [7:0]  checksum;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        in_rdy;

  logic        accept;
  logic        restart;
  logic        last_word;
  logic        chk_ok;
  logic [16:0] len_full;

  assign accept    = bus.in_valid && in_rdy;
  assign restart   = start && (state == IDLE || state == DONE || state == ERR);
  assign last_word = (words_loaded + 16'd1) == n_words;
  assign chk_ok    = bus.in_data == checksum;
  assign len_full  = {1'b0, len_hi, bus.in_data};

  assign bus.in_ready   = in_rdy;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_rdy   = 1'b0;
    case (state)
      LEN_HI: begin
        in_rdy = 1'b1;
        if (accept) state_nx = LEN_LO;
      end
      LEN_LO: begin
        in_rdy = 1'b1;
        if (accept) begin
          if (len_full > MAX_N)       state_nx = ERR;
          else if (len_full == 17'd0) state_nx = CHECK;
          else                        state_nx = DATA;
        end
      end
      DATA: begin
        in_rdy = 1'b1;
        // the final word's strobe overlaps CHECK, so the CHK byte may follow at once
        if (accept && byte_cnt == 2'd3 && last_word) state_nx = CHECK;
      end
      CHECK: begin
        in_rdy = 1'b1;
        if (accept) state_nx = chk_ok ? DONE : ERR;
      end
      default: ;
    endcase
    if (restart) state_nx = LEN_HI;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_hi       <= '0;
      n_words      <= '0;
      byte_cnt     <= '0;
      asm_word     <= '0;
      checksum     <= '0;
      we_q         <= 1'b0;
      addr_q       <= BASE_ADDR;
      wdata_q      <= '0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      we_q <= 1'b0;
      if (we_q) addr_q <= addr_q + 32'd4;
      if (accept) begin
        case (state)
          LEN_HI: len_hi <= bus.in_data;
          LEN_LO: begin
            n_words <= len_full[15:0];
            if (len_full > MAX_N) error <= 1'b1;
          end
          DATA: begin
            asm_word <= {asm_word[15:0], bus.in_data};
            checksum <= checksum ^ bus.in_data;
            byte_cnt <= byte_cnt + 2'd1;
            // wdata is its own register, so a byte taken during the strobe can't disturb it
            if (byte_cnt == 2'd3) begin
              we_q         <= 1'b1;
              wdata_q      <= {asm_word, bus.in_data};
              words_loaded <= words_loaded + 16'd1;
            end
          end
          CHECK: begin
            if (chk_ok) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (restart) begin
        cpu_hold     <= 1'b1;
        done         <= 1'b0;
        error        <= 1'b0;
        words_loaded <= '0;
        addr_q       <= BASE_ADDR;
        checksum     <= '0;
        byte_cnt     <= '0;
      end
    end
  end

  a_done_err_excl: assert property (@(posedge clk) disable iff (!rst) !(done && error));
endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame stimulus for imem_loader, checked every cycle against a
// frame-level model (byte index -> expected writes/status).
module tb_imem_loader;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        cpu_hold, done, error;
  logic [15:0] words_loaded;

  imem_loader_if bus();

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: status of the current load plus position within the frame.
  typedef enum {M_IDLE, M_LOAD, M_DONE, M_ERR} mstat_t;
  mstat_t      m_st = M_IDLE;
  int          m_idx = 0, m_n = 0, m_words = 0;
  logic [7:0]  m_hi = '0, m_chk = '0;
  logic [31:0] m_word = '0;
  bit          m_we = 1'b0;
  logic [31:0] log_addr[$], log_data[$];

  task automatic model_byte(input logic [7:0] b);
    if (m_idx == 0) m_hi = b;
    else if (m_idx == 1) begin
      m_n = int'({m_hi, b});
      if (m_n > MAXW) m_st = M_ERR;
    end else if (m_idx < 2 + 4 * m_n) begin
      m_chk ^= b;
      m_word = {m_word[23:0], b};
      if ((m_idx - 2) % 4 == 3) begin
        m_we = 1'b1;
        m_words++;
      end
    end else m_st = (b == m_chk) ? M_DONE : M_ERR;
    m_idx++;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      m_st = M_IDLE; m_words = 0; m_we = 1'b0;
    end
    chk("in_ready", bus.in_ready, 32'(m_st == M_LOAD));
    chk("imem_we", bus.imem_we, 32'(m_we));
    if (m_we) chk("imem_wdata", bus.imem_wdata, m_word);
    chk("imem_addr", bus.imem_addr, BASE + 32'(4 * (m_words - int'(m_we))));
    chk("words_loaded", words_loaded, 32'(m_words));
    chk("cpu_hold", cpu_hold, 32'(m_st == M_LOAD || m_st == M_ERR));
    chk("done", done, 32'(m_st == M_DONE));
    chk("error", error, 32'(m_st == M_ERR));
    if (bus.imem_we === 1'b1) begin
      log_addr.push_back(bus.imem_addr);
      log_data.push_back(bus.imem_wdata);
    end
    m_we = 1'b0;
    if (rst) begin
      if (start && m_st != M_LOAD) begin
        m_st = M_LOAD; m_idx = 0; m_chk = '0; m_words = 0;
      end else if (m_st == M_LOAD && bus.in_valid) model_byte(bus.in_data);
    end
  end

  logic [7:0]  fq[$];
  logic [31:0] wq[$];

  task automatic build(input int n, input bit bad);
    logic [15:0] nn;
    logic [7:0]  c;
    logic [31:0] w;
    nn = 16'(n);
    c = '0;
    fq = {};
    fq.push_back(nn[15:8]);
    fq.push_back(nn[7:0]);
    for (int i = 0; i < n; i++) begin
      w = wq[i];
      for (int k = 3; k >= 0; k--) begin
        fq.push_back(w[8*k +: 8]);
        c ^= w[8*k +: 8];
      end
    end
    fq.push_back(bad ? ~c : c);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok;
    int g;
    if (gaps) begin
      g = $urandom_range(0, 3);
      repeat (g) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        start = ($urandom_range(0, 7) == 0);  // must be ignored mid-load
        @(posedge clk); #1;
      end
      start = 1'b0;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk); #1;
    end
    if (!ok) begin
      cmp_cnt++; err_cnt++;
      $display("FAIL send_timeout: byte %h not accepted within 200 cycles", b);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gaps);
    for (int i = 0; i < fq.size(); i++) send_byte(fq[i], gaps);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
    log_addr = log_addr;
  endtask

  task automatic clear_log();
    log_addr = {};
    log_data = {};
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit bad;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #12;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_imem_we", bus.imem_we, 0);
    chk("rst_imem_addr", bus.imem_addr, BASE);
    chk("rst_imem_wdata", bus.imem_wdata, 0);
    chk("rst_cpu_hold", cpu_hold, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_words", words_loaded, 0);
    @(posedge clk); #1 rst = 1'b1;

    // single word, literal stream
    clear_log();
    pulse_start();
    fq = {8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    send_frame(1'b0);
    settle();
    chk("t1_nwr", log_addr.size(), 1);
    if (log_addr.size() >= 1) begin
      chk("t1_addr", log_addr[0], 32'h0);
      chk("t1_data", log_data[0], 32'h12345678);
    end
    chk("t1_done", done, 1);
    chk("t1_hold", cpu_hold, 0);
    chk("t1_words", words_loaded, 1);

    // three words back-to-back, good then bad checksum
    for (int pass = 0; pass < 2; pass++) begin
      clear_log();
      wq = {32'h20080005, 32'h20090007, 32'h01095020};
      pulse_start();
      build(3, pass == 1);
      send_frame(1'b0);
      settle();
      chk("t2_nwr", log_addr.size(), 3);
      if (log_addr.size() == 3) begin
        chk("t2_addr0", log_addr[0], 32'h0);
        chk("t2_addr1", log_addr[1], 32'h4);
        chk("t2_addr2", log_addr[2], 32'h8);
        chk("t2_data2", log_data[2], 32'h01095020);
      end
      chk("t2_done", done, (pass == 0) ? 1 : 0);
      chk("t2_error", error, (pass == 0) ? 0 : 1);
      chk("t2_hold", cpu_hold, (pass == 0) ? 0 : 1);
    end

    // oversize length: ERR right after LEN_LO, stream refused
    clear_log();
    pulse_start();
    fq = {8'h01, 8'h01};
    send_frame(1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    settle();
    chk("t4_ready", bus.in_ready, 0);
    chk("t4_error", error, 1);
    chk("t4_nwr", log_addr.size(), 0);
    bus.in_valid = 1'b0;

    // empty program
    clear_log();
    pulse_start();
    fq = {8'h00, 8'h00, 8'h00};
    send_frame(1'b0);
    settle();
    chk("t5_done", done, 1);
    chk("t5_nwr", log_addr.size(), 0);

    // two words with random valid gaps
    clear_log();
    wq = {32'hDEADBEEF, 32'h0BADF00D};
    pulse_start();
    build(2, 1'b0);
    send_frame(1'b1);
    settle();
    chk("t6_nwr", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      chk("t6_addr1", log_addr[1], 32'h4);
      chk("t6_data0", log_data[0], 32'hDEADBEEF);
      chk("t6_data1", log_data[1], 32'h0BADF00D);
    end
    chk("t6_done", done, 1);

    // reset mid-load after 6 payload bytes
    wq = {32'hAABBCCDD, 32'h11223344};
    pulse_start();
    build(2, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(fq[i], 1'b0);
    @(posedge clk); #3 rst = 1'b0;
    #1;
    chk("t7_in_ready", bus.in_ready, 0);
    chk("t7_imem_addr", bus.imem_addr, BASE);
    chk("t7_imem_wdata", bus.imem_wdata, 0);
    chk("t7_hold", cpu_hold, 0);
    chk("t7_words", words_loaded, 0);
    @(posedge clk); #1 rst = 1'b1;
    clear_log();
    wq = {32'hCAFEF00D};
    pulse_start();
    build(1, 1'b0);
    send_frame(1'b0);
    settle();
    chk("t7_nwr", log_addr.size(), 1);
    if (log_addr.size() == 1) begin
      chk("t7_addr", log_addr[0], BASE);
      chk("t7_data", log_data[0], 32'hCAFEF00D);
    end
    chk("t7_done", done, 1);

    // largest accepted length
    clear_log();
    wq = {};
    for (int i = 0; i < MAXW; i++) wq.push_back($urandom);
    pulse_start();
    build(MAXW, 1'b0);
    send_frame(1'b0);
    settle();
    chk("t8_nwr", log_addr.size(), MAXW);
    if (log_addr.size() == MAXW) chk("t8_last_addr", log_addr[MAXW-1], 32'h3FC);
    chk("t8_done", done, 1);

    // random frames
    for (int t = 0; t < 12; t++) begin
      clear_log();
      n = $urandom_range(0, 6);
      bad = ($urandom_range(0, 3) == 0);
      wq = {};
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      pulse_start();
      build(n, bad);
      send_frame(1'b1);
      settle();
      chk("rnd_nwr", log_addr.size(), n);
      chk("rnd_done", done, bad ? 0 : 1);
    end

    // random oversize length
    clear_log();
    n = $urandom_range(MAXW + 1, 65535);
    pulse_start();
    fq = {8'(n >> 8), 8'(n)};
    send_frame(1'b1);
    settle();
    chk("rnd_big_err", error, 1);
    chk("rnd_big_nwr", log_addr.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
